lsu_mem_ctrl: RTL and testbench

- Load/store sequencer between the MEM pipeline stage and the 32-bit data memory port.
- Accepts one request at a time.
- Generates byte strobes and lane-aligned write data.
- Aligns and sign/zero-extends read data.
- Optionally splits word-boundary-crossing accesses into two memory beats.

---
 rtl/lsu_mem_ctrl_if.sv | 44 ++++
 rtl/lsu_mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle for the load/store sequencer: request side,
// data memory beat port and completion response.
interface lsu_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [DATA_WIDTH-1:0] i_req_addr;
    logic [1:0]            i_req_size;
    logic                  i_req_unsigned;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic                  o_mem_valid;
    logic                  i_mem_ready;
    logic [DATA_WIDTH-1:0] o_mem_addr;
    logic                  o_mem_we;
    logic [3:0]            o_mem_wstrb;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  i_mem_rvalid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rsp_rdata;
    logic                  o_rsp_err;

    // Sequencer side.
    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_size,
        input  i_req_unsigned, i_req_wdata,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_req_ready, o_mem_valid, o_mem_addr, o_mem_we,
        output o_mem_wstrb, o_mem_wdata,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    // Pipeline / memory side.
    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_size,
        output i_req_unsigned, i_req_wdata,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_req_ready, o_mem_valid, o_mem_addr, o_mem_we,
        input  o_mem_wstrb, o_mem_wdata,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and the 32-bit data port.
// Define LSU_MISALIGN_SPLIT_EN to issue word-crossing accesses as two beats.
module lsu_mem_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    lsu_mem_ctrl_if.slave  bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rd0;
    logic [DATA_WIDTH-1:0]   r_rd1;

    logic                    w_fire;
    logic                    w_req_split;
    logic                    w_req_bad;
    logic [7:0]              w_mask;
    logic                    w_split;
    logic [2*DATA_WIDTH-1:0] w_data64;
    logic [DATA_WIDTH-1:0]   w_base0;
    logic [DATA_WIDTH-1:0]   w_base1;
    logic [DATA_WIDTH-1:0]   w_rd_sh;
    logic [DATA_WIDTH-1:0]   w_load;

    // Byte-lane mask over two consecutive words.
    function automatic logic [7:0] f_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'h00;
        endcase
        return m << off;
    endfunction

    assign w_fire      = bus.i_req_valid & (r_state == S_IDLE);
    assign w_req_split = f_mask(bus.i_req_size, bus.i_req_addr[1:0]) > 8'h0F;
    assign w_req_bad   = (bus.i_req_size == 2'b11) |
                         (w_req_split & ~SPLIT_EN);

    assign w_mask   = f_mask(r_size, r_addr[1:0]);
    assign w_split  = (w_mask[7:4] != 4'h0) & SPLIT_EN;
    assign w_data64 = {{DATA_WIDTH{1'b0}}, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_base0  = {r_addr[DATA_WIDTH-1:2], 2'b00};
    assign w_base1  = w_base0 + 32'd4;
    assign w_rd_sh  = 32'({r_rd1, r_rd0} >> {r_addr[1:0], 3'b000});

    // Select and extend the aligned load lanes.
    always_comb begin
        w_load = w_rd_sh;
        case (r_size)
            2'b00: w_load = r_uns ? {24'h0, w_rd_sh[7:0]}
                                  : {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
            2'b01: w_load = r_uns ? {16'h0, w_rd_sh[15:0]}
                                  : {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
            default: w_load = w_rd_sh;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_fire) w_next = w_req_bad ? S_RESP : S_ISSUE0;
            end
            S_ISSUE0: begin
                if (bus.i_mem_ready) begin
                    if (!r_we)       w_next = S_WAIT0;
                    else if (w_split) w_next = S_ISSUE1;
                    else             w_next = S_RESP;
                end
            end
            S_WAIT0: begin
                if (bus.i_mem_rvalid) w_next = w_split ? S_ISSUE1 : S_RESP;
            end
            S_ISSUE1: begin
                if (bus.i_mem_ready) w_next = r_we ? S_RESP : S_WAIT1;
            end
            S_WAIT1: begin
                if (bus.i_mem_rvalid) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture and read-data collection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            if (w_fire) begin
                r_we    <= bus.i_req_we;
                r_addr  <= bus.i_req_addr;
                r_size  <= bus.i_req_size;
                r_uns   <= bus.i_req_unsigned;
                r_wdata <= bus.i_req_wdata;
                r_err   <= w_req_bad;
                r_rd0   <= '0;
                r_rd1   <= '0;
            end
            if (r_state == S_WAIT0 && bus.i_mem_rvalid) r_rd0 <= bus.i_mem_rdata;
            if (r_state == S_WAIT1 && bus.i_mem_rvalid) r_rd1 <= bus.i_mem_rdata;
        end
    end

    // Per-state outputs; everything idles at zero.
    always_comb begin
        bus.o_req_ready = 1'b0;
        bus.o_mem_valid = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_wstrb = 4'h0;
        bus.o_mem_wdata = '0;
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_rdata = '0;
        bus.o_rsp_err   = 1'b0;
        unique case (r_state)
            S_IDLE: bus.o_req_ready = ~i_rst;
            S_ISSUE0: begin
                bus.o_mem_valid = 1'b1;
                bus.o_mem_addr  = w_base0;
                bus.o_mem_we    = r_we;
                if (r_we) begin
                    bus.o_mem_wstrb = w_mask[3:0];
                    bus.o_mem_wdata = w_data64[DATA_WIDTH-1:0];
                end
            end
            S_ISSUE1: begin
                bus.o_mem_valid = 1'b1;
                bus.o_mem_addr  = w_base1;
                bus.o_mem_we    = r_we;
                if (r_we) begin
                    bus.o_mem_wstrb = w_mask[7:4];
                    bus.o_mem_wdata = w_data64[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            S_RESP: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_rsp_err   = r_err;
                if (!r_we && !r_err) bus.o_rsp_rdata = w_load;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected
// beats/responses; a negedge monitor pops and compares.
module tb_lsu_mem_ctrl;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.DATA_WIDTH(32)) bus ();

    lsu_mem_ctrl #(.DATA_WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    rsp_t        rspq[$];
    beat_t       beatq[$];
    logic [31:0] rdq[$];

    int    cyc      = 0;
    int    nvec     = 0;
    int    nmiss    = 0;
    int    wait_cnt = 0;
    bit    no_rv    = 0;
    bit    force_rv = 0;
    bit    stall_en = 0;
    bit    chk_zero = 0;
    bit    chk_end  = 0;
    bit    prev_st  = 0;
    beat_t held;

    assign bus.i_mem_ready = !(stall_en && wait_cnt < 3);

    // Memory responder: read data one cycle after a read beat handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.i_mem_rvalid <= 1'b0;
        bus.i_mem_rdata  <= 32'h0;
        if (bus.o_mem_valid && !bus.i_mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.o_mem_valid && bus.i_mem_ready && !bus.o_mem_we && !no_rv) begin
            bus.i_mem_rvalid <= 1'b1;
            bus.i_mem_rdata  <= (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
        end
        if (force_rv) begin
            bus.i_mem_rvalid <= 1'b1;
            bus.i_mem_rdata  <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: all comparisons happen here.
    always @(negedge clk) begin
        beat_t cur;
        if (chk_zero)
            chk("outputs_zero_in_reset",
                80'({bus.o_req_ready, bus.o_mem_valid, bus.o_mem_we,
                     bus.o_mem_wstrb, bus.o_rsp_valid, bus.o_rsp_err,
                     (bus.o_mem_addr | bus.o_mem_wdata | bus.o_rsp_rdata)}),
                80'h0);
        if (!rst && bus.o_rsp_valid) begin
            if (rspq.size() == 0) begin
                nvec++;
                nmiss++;
                $display("FAIL unexpected_rsp: got rdata %h err %0b expected none",
                         bus.o_rsp_rdata, bus.o_rsp_err);
            end else begin
                rsp_t r;
                r = rspq.pop_front();
                chk("rsp_rdata", 80'(bus.o_rsp_rdata), 80'(r.rd));
                chk("rsp_err", 80'(bus.o_rsp_err), 80'(r.err));
                if (r.cyc >= 0) chk("rsp_cycle", 80'(cyc), 80'(r.cyc));
            end
        end
        if (!rst && bus.o_mem_valid) begin
            cur = '{bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wstrb, bus.o_mem_wdata};
            chk("req_ready_busy", 80'(bus.o_req_ready), 80'(0));
            if (prev_st)
                chk("beat_stable",
                    80'({cur.addr, cur.we, cur.strb, cur.wdata}),
                    80'({held.addr, held.we, held.strb, held.wdata}));
            if (bus.i_mem_ready) begin
                if (beatq.size() == 0) begin
                    nvec++;
                    nmiss++;
                    $display("FAIL unexpected_beat: got addr %h expected none", cur.addr);
                end else begin
                    beat_t b;
                    b = beatq.pop_front();
                    chk("beat_addr", 80'(cur.addr), 80'(b.addr));
                    chk("beat_we", 80'(cur.we), 80'(b.we));
                    chk("beat_strb", 80'(cur.strb), 80'(b.strb));
                    chk("beat_wdata", 80'(cur.wdata), 80'(b.wdata));
                end
            end
            prev_st = !bus.i_mem_ready;
            held    = cur;
        end else begin
            prev_st = 1'b0;
        end
        if (chk_end)
            chk("queues_drained",
                80'(rspq.size() + beatq.size() + rdq.size()), 80'(0));
    end

    task automatic pb(input logic [31:0] a, input logic we,
                      input logic [3:0] s, input logic [31:0] d);
        beatq.push_back('{a, we, s, d});
    endtask

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] wd, input logic [31:0] erd,
                         input logic eerr, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_req_ready) begin
            n++;
            if (n > 50) begin
                $display("FAIL issue_timeout: got no o_req_ready expected ready");
                $fatal(1, "request never accepted");
            end
            @(negedge clk);
        end
        bus.i_req_we       = we;
        bus.i_req_addr     = a;
        bus.i_req_size     = sz;
        bus.i_req_unsigned = u;
        bus.i_req_wdata    = wd;
        bus.i_req_valid    = 1'b1;
        rspq.push_back('{erd, eerr, (lat < 0) ? -1 : cyc + lat});
        @(posedge clk);
        #1 bus.i_req_valid = 1'b0;
        n = 0;
        while (rspq.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                $display("FAIL rsp_timeout: got no o_rsp_valid expected response");
                $fatal(1, "response never arrived");
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.i_req_valid    = 1'b0;
        bus.i_req_we       = 1'b0;
        bus.i_req_addr     = 32'h0;
        bus.i_req_size     = 2'b00;
        bus.i_req_unsigned = 1'b0;
        bus.i_req_wdata    = 32'h0;
        repeat (2) @(posedge clk);
        #1 chk_zero = 1;
        @(negedge clk);
        #1 chk_zero = 0;
        rst = 1'b0;

        // Store byte at offset 3.
        pb(32'h100, 1, 4'b1000, 32'hAB00_0000);
        issue(1, 32'h103, 2'b00, 0, 32'h0000_00AB, 32'h0, 0, 2);
        // Signed and unsigned halfword loads at offset 2.
        pb(32'h200, 0, 4'b0000, 32'h0);
        rdq.push_back(32'h8001_1234);
        issue(0, 32'h202, 2'b01, 0, 32'h0, 32'hFFFF_8001, 0, 3);
        pb(32'h200, 0, 4'b0000, 32'h0);
        rdq.push_back(32'h8001_1234);
        issue(0, 32'h202, 2'b01, 1, 32'h0, 32'h0000_8001, 0, 3);
        // Byte loads, signed and unsigned.
        pb(32'h004, 0, 4'b0000, 32'h0);
        rdq.push_back(32'h8000_0000);
        issue(0, 32'h007, 2'b00, 0, 32'h0, 32'hFFFF_FF80, 0, 3);
        pb(32'h004, 0, 4'b0000, 32'h0);
        rdq.push_back(32'h0000_AB00);
        issue(0, 32'h005, 2'b00, 1, 32'h0, 32'h0000_00AB, 0, 3);
        // Aligned word load and store.
        pb(32'h020, 0, 4'b0000, 32'h0);
        rdq.push_back(32'hCAFE_BABE);
        issue(0, 32'h020, 2'b10, 0, 32'h0, 32'hCAFE_BABE, 0, 3);
        pb(32'h044, 1, 4'b1111, 32'hA5A5_5A5A);
        issue(1, 32'h044, 2'b10, 0, 32'hA5A5_5A5A, 32'h0, 0, 2);

`ifdef LSU_MISALIGN_SPLIT_EN
        pb(32'h300, 1, 4'b1110, 32'h2233_4400);
        pb(32'h304, 1, 4'b0001, 32'h0000_0011);
        issue(1, 32'h301, 2'b10, 0, 32'h1122_3344, 32'h0, 0, 3);
        pb(32'h304, 0, 4'b0000, 32'h0);
        pb(32'h308, 0, 4'b0000, 32'h0);
        rdq.push_back(32'hDDCC_0000);
        rdq.push_back(32'h0000_BBAA);
        issue(0, 32'h306, 2'b10, 0, 32'h0, 32'hBBAA_DDCC, 0, 5);
        pb(32'hFFFF_FFFC, 1, 4'b1000, 32'hEF00_0000);
        pb(32'h0000_0000, 1, 4'b0001, 32'h0000_00BE);
        issue(1, 32'hFFFF_FFFF, 2'b01, 0, 32'h0000_BEEF, 32'h0, 0, 3);
`else
        issue(1, 32'h301, 2'b10, 0, 32'h1122_3344, 32'h0, 1, 1);
        issue(0, 32'h306, 2'b10, 0, 32'h0, 32'h0, 1, 1);
        issue(1, 32'hFFFF_FFFF, 2'b01, 0, 32'h0000_BEEF, 32'h0, 1, 1);
`endif

        // Memory stalls three cycles on an aligned half store.
        stall_en = 1;
        pb(32'h010, 1, 4'b0011, 32'h1234_5678);
        issue(1, 32'h010, 2'b01, 0, 32'h1234_5678, 32'h0, 0, -1);
        stall_en = 0;
        // Reserved size: immediate error, no beat.
        issue(0, 32'h0, 2'b11, 0, 32'h0, 32'h0, 1, 1);

        // Reset while waiting for read data.
        no_rv = 1;
        pb(32'h040, 0, 4'b0000, 32'h0);
        @(negedge clk);
        bus.i_req_we       = 1'b0;
        bus.i_req_addr     = 32'h040;
        bus.i_req_size     = 2'b10;
        bus.i_req_unsigned = 1'b0;
        bus.i_req_valid    = 1'b1;
        @(posedge clk);
        #1 bus.i_req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        chk_zero = 1;
        @(negedge clk);
        #1 chk_zero = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        no_rv = 0;
        @(posedge clk);
        #1 force_rv = 1;
        @(posedge clk);
        #1 force_rv = 0;
        repeat (6) @(posedge clk);

        #1 chk_end = 1;
        @(negedge clk);
        #1 chk_end = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
